// File: rtl/testrig_mem_pkg.sv
// Shared types and constants for the TestRIG data-SRAM arbiter.
// Holds the quiesce FSM states, the host indices, the default address window and the range-check helper.
package testrig_mem_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2
  } arb_state_e;

  localparam logic HOST_CORE    = 1'b0;
  localparam logic HOST_HARNESS = 1'b1;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'h007F_FFFF;

  // Inclusive window base..base+mask; the subtraction keeps this correct for an unaligned base.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off <= mask);
  endfunction

endpackage

// File: rtl/testrig_rr_arb2.sv
// Two-input round-robin picker: grants at most one eligible requester per cycle.
// The preferred host flips to the other side after every grant.
module testrig_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic       prio_q;
  logic       prio_d;
  logic [1:0] elig;

  always_comb begin
    elig      = req_i & en_i;
    gnt_o     = 2'b00;
    prio_d    = prio_q;
    gnt_idx_o = elig[prio_q] ? prio_q : ~prio_q;
    if (|elig) begin
      gnt_o[gnt_idx_o] = 1'b1;
      prio_d           = ~gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/testrig_mem_arbiter.sv
// Shares the single-port data SRAM between the core (host 0) and the harness (host 1), with a quiesce handshake.
// Optional out-of-range rejection is compiled in with TESTRIG_MEM_RANGE_CHK_EN.
module testrig_mem_arbiter
  import testrig_mem_pkg::*;
#(
  parameter logic [31:0] AddrBase  = DEF_ADDR_BASE,
  parameter logic [31:0] AddrMask  = DEF_ADDR_MASK,
  parameter int unsigned DataWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  h_req_i,
  output logic [1:0]                  h_gnt_o,
  input  logic [1:0]                  h_we_i,
  input  logic [1:0][DataWidth/8-1:0] h_be_i,
  input  logic [1:0][31:0]            h_addr_i,
  input  logic [1:0][DataWidth-1:0]   h_wdata_i,
  output logic [1:0]                  h_rvalid_o,
  output logic [DataWidth-1:0]        h_rdata_o,
  output logic [1:0]                  h_err_o,
  output logic                        ram_req_o,
  output logic                        ram_we_o,
  output logic [DataWidth/8-1:0]      ram_be_o,
  output logic [31:0]                 ram_addr_o,
  output logic [DataWidth-1:0]        ram_wdata_o,
  input  logic                        ram_rvalid_i,
  input  logic [DataWidth-1:0]        ram_rdata_i,
  input  logic                        quiesce_i,
  output logic                        quiesced_o
);

`ifdef TESTRIG_MEM_RANGE_CHK_EN
  localparam logic RangeChk = 1'b1;
`else
  localparam logic RangeChk = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_host_q, rsp_host_d;
  logic       rsp_err_q, rsp_err_d;
  logic       proto_err_q, proto_err_d;

  logic [1:0] arb_en;
  logic       sel;
  logic       gnt_any;
  logic       req_err;

  // Grants are masked while reset is held so nothing is accepted that could not be answered.
  always_comb begin
    arb_en = 2'b00;
    if (!rst_i) begin
      arb_en[HOST_HARNESS] = 1'b1;
      arb_en[HOST_CORE]    = (state_q == RUN);
    end
  end

  testrig_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (h_req_i),
    .en_i      (arb_en),
    .gnt_o     (h_gnt_o),
    .gnt_idx_o (sel)
  );

  always_comb begin
    gnt_any     = |h_gnt_o;
    req_err     = RangeChk & ~in_range(h_addr_i[sel], AddrBase, AddrMask);

    ram_req_o   = gnt_any & ~req_err;
    ram_we_o    = ram_req_o & h_we_i[sel];
    ram_be_o    = h_be_i[sel];
    ram_addr_o  = h_addr_i[sel] & AddrMask;
    ram_wdata_o = h_wdata_i[sel];

    rsp_vld_d   = gnt_any;
    rsp_host_d  = sel;
    rsp_err_d   = gnt_any & req_err;

    h_rvalid_o  = 2'b00;
    h_err_o     = 2'b00;
    h_rvalid_o[rsp_host_q] = rsp_vld_q;
    h_err_o[rsp_host_q]    = rsp_vld_q & rsp_err_q;
    h_rdata_o   = (rsp_vld_q && !rsp_err_q) ? ram_rdata_i : '0;

    // An SRAM response nobody asked for means the fixed-latency contract is broken.
    proto_err_d = proto_err_q | (ram_rvalid_i & (~rsp_vld_q | rsp_err_q));
  end

  always_comb begin
    state_d    = state_q;
    quiesced_o = (state_q == QUIESCED);
    case (state_q)
      RUN: begin
        if (quiesce_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!quiesce_i)                    state_d = RUN;
        else if (!rsp_vld_q || rsp_host_q) state_d = QUIESCED;
      end
      QUIESCED: begin
        if (!quiesce_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      rsp_vld_q   <= 1'b0;
      rsp_host_q  <= HOST_CORE;
      rsp_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_host_q  <= rsp_host_d;
      rsp_err_q   <= rsp_err_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifndef SYNTHESIS
  a_no_proto_err: assert property (@(posedge clk_i) disable iff (rst_i) !proto_err_q);
`endif

endmodule

// File: tb/tb_testrig_mem_arbiter.sv
// Directed bench for testrig_mem_arbiter with a one-cycle SRAM model; expectations follow the range-check build option.
module tb_testrig_mem_arbiter;

`ifdef TESTRIG_MEM_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]       h_req_i, h_we_i, h_gnt_o, h_rvalid_o, h_err_o;
  logic [1:0][3:0]  h_be_i;
  logic [1:0][31:0] h_addr_i, h_wdata_i;
  logic [31:0]      h_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]       ram_be_o;
  logic             ram_req_o, ram_we_o, ram_rvalid_i, quiesce_i, quiesced_o;

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  testrig_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .h_req_i(h_req_i), .h_gnt_o(h_gnt_o), .h_we_i(h_we_i), .h_be_i(h_be_i),
    .h_addr_i(h_addr_i), .h_wdata_i(h_wdata_i),
    .h_rvalid_o(h_rvalid_o), .h_rdata_o(h_rdata_o), .h_err_o(h_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .quiesce_i(quiesce_i), .quiesced_o(quiesced_o)
  );

  // SRAM model: word index from address bits [9:2]; preloaded with 0xA500_00<idx> on reset.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_rvalid_i <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    end else begin
      ram_rvalid_i <= ram_req_o;
      if (ram_req_o) begin
        ram_rdata_i <= mem[ram_addr_o[9:2]];
        if (ram_we_o)
          for (int b = 0; b < 4; b++)
            if (ram_be_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic host(input int h, input logic req, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    h_req_i[h]   = req;
    h_we_i[h]    = we;
    h_addr_i[h]  = addr;
    h_wdata_i[h] = wdata;
    h_be_i[h]    = 4'hF;
  endtask

  task automatic test_reset();
    h_req_i = '0; h_we_i = '0; h_be_i = '0; h_addr_i = '0; h_wdata_i = '0; quiesce_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    host(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    #1;
    n_checks++;
    if ({h_gnt_o, h_rvalid_o, h_err_o, ram_req_o, quiesced_o} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000", {h_gnt_o, h_rvalid_o, h_err_o, ram_req_o, quiesced_o});
    end
    n_checks++;
    if (h_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00000000", h_rdata_o);
    end
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_gnt, prev_gnt;
    logic [31:0] exp_addr, prev_data;
    prev_gnt  = 2'b00;
    prev_data = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      host(0, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
      host(1, 1'b1, 1'b0, 32'h8000_0040, 32'h0);
      #1;
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h0000_0020 : 32'h0000_0040;
      n_checks++;
      if ({h_gnt_o, ram_addr_o} !== {exp_gnt, exp_addr}) begin
        n_fail++;
        $display("FAIL alt_gnt[%0d]: got gnt=%b addr=%h want gnt=%b addr=%h", k, h_gnt_o, ram_addr_o, exp_gnt, exp_addr);
      end
      if (k > 0) begin
        n_checks++;
        if ({h_rvalid_o, h_rdata_o} !== {prev_gnt, prev_data}) begin
          n_fail++;
          $display("FAIL alt_rsp[%0d]: got rv=%b data=%h want rv=%b data=%h", k, h_rvalid_o, h_rdata_o, prev_gnt, prev_data);
        end
      end
      prev_gnt  = exp_gnt;
      prev_data = (k % 2 == 0) ? 32'hA500_0008 : 32'hA500_0010;
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    host(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_rdata_o} !== {2'b10, 32'hA500_0010}) begin
      n_fail++; $display("FAIL alt_last: got rv=%b data=%h want rv=10 data=a5000010", h_rvalid_o, h_rdata_o);
    end
  endtask

  task automatic test_core_read();
    @(negedge clk_i);
    host(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    #1;
    n_checks++;
    if ({h_gnt_o, ram_req_o, ram_we_o, ram_addr_o} !== {2'b01, 1'b1, 1'b0, 32'h0000_0010}) begin
      n_fail++;
      $display("FAIL rd_issue: got gnt=%b req=%b we=%b addr=%h want gnt=01 req=1 we=0 addr=00000010",
               h_gnt_o, ram_req_o, ram_we_o, ram_addr_o);
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_err_o, h_rdata_o} !== {2'b01, 2'b00, 32'hA500_0004}) begin
      n_fail++;
      $display("FAIL rd_rsp: got rv=%b err=%b data=%h want rv=01 err=00 data=a5000004", h_rvalid_o, h_err_o, h_rdata_o);
    end
  endtask

  task automatic test_range();
    logic [31:0] mem0;
    logic [1:0]  exp_err;
    mem0    = RCHK ? 32'hA500_0000 : 32'hDEAD_BEEF;
    exp_err = RCHK ? 2'b01 : 2'b00;
    // Core write below the window: rejected when checked, aliases onto word 0 otherwise.
    @(negedge clk_i);
    host(0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if ({h_gnt_o, ram_req_o} !== {2'b01, !RCHK}) begin
      n_fail++; $display("FAIL oor_wr_issue: got gnt=%b req=%b want gnt=01 req=%b", h_gnt_o, ram_req_o, !RCHK);
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    host(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_err_o, h_gnt_o} !== {2'b01, exp_err, 2'b10}) begin
      n_fail++;
      $display("FAIL oor_wr_rsp: got rv=%b err=%b gnt=%b want rv=01 err=%b gnt=10", h_rvalid_o, h_err_o, h_gnt_o, exp_err);
    end
    @(negedge clk_i);
    host(1, 1'b0, 1'b0, 32'h0, 32'h0);
    host(0, 1'b1, 1'b0, 32'h807F_FFFC, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_err_o, h_rdata_o} !== {2'b10, 2'b00, mem0}) begin
      n_fail++; $display("FAIL mem0_after_wr: got rv=%b err=%b data=%h want rv=10 err=00 data=%h", h_rvalid_o, h_err_o, h_rdata_o, mem0);
    end
    n_checks++;
    if ({h_gnt_o, ram_req_o, ram_addr_o} !== {2'b01, 1'b1, 32'h007F_FFFC}) begin
      n_fail++; $display("FAIL top_issue: got gnt=%b req=%b addr=%h want gnt=01 req=1 addr=007ffffc", h_gnt_o, ram_req_o, ram_addr_o);
    end
    @(negedge clk_i);
    host(0, 1'b1, 1'b0, 32'h8080_0000, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_err_o, h_rdata_o} !== {2'b01, 2'b00, 32'hA500_00FF}) begin
      n_fail++; $display("FAIL top_rsp: got rv=%b err=%b data=%h want rv=01 err=00 data=a50000ff", h_rvalid_o, h_err_o, h_rdata_o);
    end
    n_checks++;
    if ({h_gnt_o, ram_req_o} !== {2'b01, !RCHK}) begin
      n_fail++; $display("FAIL past_top_issue: got gnt=%b req=%b want gnt=01 req=%b", h_gnt_o, ram_req_o, !RCHK);
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_err_o, h_rdata_o} !== {2'b01, exp_err, (RCHK ? 32'h0 : 32'hDEAD_BEEF)}) begin
      n_fail++; $display("FAIL past_top_rsp: got rv=%b err=%b data=%h want rv=01 err=%b", h_rvalid_o, h_err_o, h_rdata_o, exp_err);
    end
  endtask

  task automatic test_quiesce();
    @(negedge clk_i);
    quiesce_i = 1'b1;
    host(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    #1;
    n_checks++;
    if ({h_gnt_o, quiesced_o} !== {2'b01, 1'b0}) begin
      n_fail++; $display("FAIL q_c0: got gnt=%b q=%b want gnt=01 q=0", h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_rdata_o, h_gnt_o, quiesced_o} !== {2'b01, 32'hA500_0004, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL q_c1: got rv=%b data=%h gnt=%b q=%b want rv=01 data=a5000004 gnt=00 q=0", h_rvalid_o, h_rdata_o, h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    host(1, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
    #1;
    n_checks++;
    if ({h_gnt_o, quiesced_o} !== {2'b10, 1'b0}) begin
      n_fail++; $display("FAIL q_c2: got gnt=%b q=%b want gnt=10 q=0", h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    host(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_rdata_o, h_gnt_o, quiesced_o} !== {2'b10, 32'hA500_0008, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL q_c3: got rv=%b data=%h gnt=%b q=%b want rv=10 data=a5000008 gnt=00 q=1", h_rvalid_o, h_rdata_o, h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    quiesce_i = 1'b0;
    #1;
    n_checks++;
    if ({h_gnt_o, quiesced_o} !== {2'b00, 1'b1}) begin
      n_fail++; $display("FAIL q_c4: got gnt=%b q=%b want gnt=00 q=1", h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({h_gnt_o, quiesced_o} !== {2'b01, 1'b0}) begin
      n_fail++; $display("FAIL q_c5: got gnt=%b q=%b want gnt=01 q=0", h_gnt_o, quiesced_o);
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_rdata_o} !== {2'b01, 32'hA500_0004}) begin
      n_fail++; $display("FAIL q_c6: got rv=%b data=%h want rv=01 data=a5000004", h_rvalid_o, h_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    host(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    #1;
    n_checks++;
    if (h_gnt_o !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_gnt: got %b want 01", h_gnt_o);
    end
    @(posedge clk_i);
    #1;
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({h_gnt_o, h_rvalid_o, h_err_o, ram_req_o, quiesced_o, h_rdata_o} !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: got gnt=%b rv=%b err=%b req=%b q=%b data=%h want all 0",
               h_gnt_o, h_rvalid_o, h_err_o, ram_req_o, quiesced_o, h_rdata_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (h_rvalid_o !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_norv: got %b want 00", h_rvalid_o);
    end
    @(negedge clk_i);
    host(0, 1'b1, 1'b0, 32'h8000_0030, 32'h0);
    host(1, 1'b1, 1'b0, 32'h8000_0040, 32'h0);
    #1;
    n_checks++;
    if (h_gnt_o !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_first: got %b want 01", h_gnt_o);
    end
    @(negedge clk_i);
    host(0, 1'b0, 1'b0, 32'h0, 32'h0);
    host(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({h_rvalid_o, h_rdata_o} !== {2'b01, 32'hA500_000C}) begin
      n_fail++; $display("FAIL rst_mid_rsp: got rv=%b data=%h want rv=01 data=a500000c", h_rvalid_o, h_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_core_read();
    test_range();
    test_quiesce();
    test_reset_mid();
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/testrig_mem_arbiter.md
# testrig_mem_arbiter

Two-host arbiter and sequencer for the single-port data SRAM in the TestRIG harness. Shares the SRAM between the Ibex data port (host 0) and the harness preload/inspection port (host 1) with round-robin grants. Performs address-range checking and routes the fixed one-cycle SRAM response back to its issuer. Provides a quiesce handshake so the harness can drain core traffic before touching memory.

## Interface
- AddrBase, 32'h8000_0000, lowest legal byte address
- AddrMask, 32'h007F_FFFF, legal range is AddrBase..AddrBase+AddrMask inclusive
- DataWidth, 32, data bus width (BE width = DataWidth/8)
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- h_req_i  in  [2]  request per host (index 0 = core, 1 = harness)
- h_gnt_o  out  [2]  grant, same cycle as accepted request
- h_we_i  in  [2]  write enable per host
- h_be_i  in  [2][DataWidth/8]  byte enables per host
- h_addr_i  in  [2][32]  byte address per host
- h_wdata_i  in  [2][DataWidth]  write data per host
- h_rvalid_o  out  [2]  response valid per host
- h_rdata_o  out  DataWidth  read data, shared, valid with h_rvalid_o
- h_err_o  out  [2]  error, qualified by h_rvalid_o
- ram_req_o / ram_we_o  out  1  SRAM request / write enable
- ram_be_o  out  DataWidth/8  SRAM byte enables
- ram_addr_o  out  32  SRAM address (h_addr_i & AddrMask)
- ram_wdata_o  out  DataWidth  SRAM write data
- ram_rvalid_i  in  1  SRAM response, exactly one cycle after ram_req_o
- ram_rdata_i  in  DataWidth  SRAM read data
- quiesce_i  in  1  harness request to block host 0
- quiesced_o  out  1  host 0 blocked and no host-0 response pending

## Operation
- Arbitration: round-robin over eligible requesters; prio_q names the preferred host; after a grant to host n, prio_q <= ~n. Host 0 is ineligible unless state == RUN.
- At most one grant per cycle; h_gnt_o is combinational from h_req_i, prio_q, state.
- In-range granted request: forwarded to SRAM same cycle (ram_req_o=1). Out-of-range (with TESTRIG_MEM_RANGE_CHK_EN): granted, not forwarded, ram_req_o=0.
- Response register: rsp_vld_q, rsp_host_q, rsp_err_q loaded on every grant. Next cycle h_rvalid_o[rsp_host_q]=1; h_err_o[rsp_host_q]=rsp_err_q; h_rdata_o=ram_rdata_i (0 when rsp_err_q).
- Back-to-back grants allowed every cycle; responses are in order with fixed latency 1.
- Quiesce FSM (states RUN, DRAIN, QUIESCED):
  - RUN -> DRAIN when quiesce_i=1.
  - DRAIN -> QUIESCED when no host-0 response pending (rsp_vld_q=0 or rsp_host_q=1).
  - DRAIN/QUIESCED -> RUN when quiesce_i=0.
  - QUIESCED: quiesced_o=1; host 1 still served.
- ram_rvalid_i with rsp_vld_q=0 or rsp_err_q=1: ignored; sticky protocol error flag asserts in simulation.

## Timing
- Reset values: h_gnt_o=0, h_rvalid_o=0, h_err_o=0, h_rdata_o=0, ram_req_o=0, quiesced_o=0, prio_q=0 (core), state=RUN.
- Grant-to-rvalid latency: exactly 1 cycle, including error responses.
- Simultaneous requests: prio_q host wins; loser holds req and is granted next cycle (no starvation beyond 1 cycle).
- quiesce_i raised in the same cycle as a host-0 request: host 0 is still granted (state updates next edge); QUIESCED follows 2 cycles later.
- Reset mid-transaction: pending response dropped, no rvalid issued after reset release.

## Configuration
- TESTRIG_MEM_RANGE_CHK_EN defined: out-of-range requests get err=1, never reach the SRAM (writes cannot alias).
- Undefined: no range check; every granted request is forwarded with masked address, h_err_o tied 0.

## Structure
- testrig_mem_pkg: arb_state_e (RUN/DRAIN/QUIESCED), host index constants HOST_CORE=0/HOST_HARNESS=1, default AddrBase/AddrMask.
- One sub-module: testrig_rr_arb2 (two-input round-robin picker with enable mask and priority update).

## Test plan
- Core read at 32'h8000_0010 alone -> gnt same cycle, ram_addr_o=32'h0000_0010, rvalid[0] next cycle with ram data, err=0.
- Both hosts request every cycle for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; responses routed in same order.
- Core write to 32'h0000_1000 (check enabled) -> gnt, ram_req_o=0, rvalid[0]=1 err[0]=1 next cycle; SRAM contents unchanged.
- quiesce_i=1 with core request in flight -> core response delivered, quiesced_o=1 two cycles later, further core reqs ungranted while harness reads still complete; drop quiesce_i -> core granted next cycle.
- Assert rst_i the cycle after a grant -> no rvalid emitted; all outputs at reset values; first post-reset grant goes to core.
- Address 32'h807F_FFFC vs 32'h8080_0000 -> first in range (err=0), second err=1.
